// File: rtl/multibank_buff_ctrl_pkg.sv
// Shared defaults for the multi-bank frame buffer and the blocks that instantiate it.
package multibank_buff_ctrl_pkg;

  localparam int BUF_WIDTH = 16;
  localparam int BUF_DEPTH = 64;
  localparam int BUF_NBANK = 2;

endpackage : multibank_buff_ctrl_pkg

// File: rtl/multibank_buff_ctrl_bank_ram.sv
// Simple dual-port storage for all banks: synchronous write, registered read.
module multibank_buff_ctrl_bank_ram #(
  parameter int WIDTH = 16,
  parameter int WORDS = 128,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [WORDS];
  logic [WIDTH-1:0] rdata_d;
  logic [WIDTH-1:0] rdata_q;

  // Storage write port.
  // NOTE: the array is deliberately left without a reset so it maps onto RAM macros;
  // stale contents are never exposed because no bank is marked full after reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read data: load on a read, otherwise hold the last word read.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  // Read output register; cleared on reset so the buffer output reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule : multibank_buff_ctrl_bank_ram

// File: rtl/multibank_buff_ctrl.sv
// Toggle-controlled multi-bank frame buffer: the writer fills banks in turn, the
// reader drains only banks that have been completely filled, preserving word order.
module multibank_buff_ctrl
  import multibank_buff_ctrl_pkg::*;
#(
  parameter int WIDTH  = BUF_WIDTH,
  parameter int DEPTH  = BUF_DEPTH,
  parameter int NBANK  = BUF_NBANK,
  parameter int LDEPTH = $clog2(DEPTH),
  parameter int LBANK  = $clog2(NBANK)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_toggle,
  input  logic             rd_toggle,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic [LBANK:0]   full_banks,
  output logic             wr_busy,
  output logic             rd_busy,
  output logic             wr_ovf,
  output logic             rd_udf
);

  localparam int WORDS = NBANK * DEPTH;
  localparam int AW    = $clog2(WORDS);

  localparam logic [LDEPTH-1:0] LAST_PTR  = LDEPTH'(DEPTH - 1);
  localparam logic [LDEPTH-1:0] PTR_ONE   = LDEPTH'(1);
  localparam logic [LBANK-1:0]  LAST_BANK = LBANK'(NBANK - 1);
  localparam logic [LBANK-1:0]  BANK_ONE  = LBANK'(1);
  localparam logic [LBANK:0]    CNT_ONE   = (LBANK + 1)'(1);

  logic              wr_busy_d,    wr_busy_q;
  logic              rd_busy_d,    rd_busy_q;
  logic [LDEPTH-1:0] wr_ptr_d,     wr_ptr_q;
  logic [LDEPTH-1:0] rd_ptr_d,     rd_ptr_q;
  logic [LBANK-1:0]  wr_bank_d,    wr_bank_q;
  logic [LBANK-1:0]  rd_bank_d,    rd_bank_q;
  logic [NBANK-1:0]  bank_full_d,  bank_full_q;
  logic [LBANK:0]    full_banks_d, full_banks_q;
  logic              wr_ovf_d,     wr_ovf_q;
  logic              rd_udf_d,     rd_udf_q;
  logic              data_valid_d, data_valid_q;

  logic          wr_req, wr_accept, wr_wrap;
  logic          rd_req, rd_accept, rd_wrap;
  logic [AW-1:0] wr_addr, rd_addr;

  // The toggle cycle itself already requests a transfer, on both start and stop pulses.
  assign wr_req    = wr_busy_q | wr_toggle;
  assign rd_req    = rd_busy_q | rd_toggle;
  assign wr_accept = wr_req & ~bank_full_q[wr_bank_q];
  assign rd_accept = rd_req &  bank_full_q[rd_bank_q];
  assign wr_wrap   = wr_accept & (wr_ptr_q == LAST_PTR);
  assign rd_wrap   = rd_accept & (rd_ptr_q == LAST_PTR);

  // Flat RAM address: bank base plus word offset (DEPTH need not be a power of two).
  assign wr_addr = AW'(wr_bank_q) * AW'(DEPTH) + AW'(wr_ptr_q);
  assign rd_addr = AW'(rd_bank_q) * AW'(DEPTH) + AW'(rd_ptr_q);

  // Next-state logic for pointers, bank-full tracking, occupancy counter and flags.
  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    wr_busy_d    = wr_busy_q ^ wr_toggle;
    rd_busy_d    = rd_busy_q ^ rd_toggle;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    bank_full_d  = bank_full_q;
    full_banks_d = full_banks_q;

    if (wr_accept) begin
      if (wr_wrap) begin
        wr_ptr_d               = '0;
        wr_bank_d              = (wr_bank_q == LAST_BANK) ? '0 : wr_bank_q + BANK_ONE;
        bank_full_d[wr_bank_q] = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
    end

    // The writer only targets non-full banks and the reader only full ones, so the
    // set above and the clear below can never hit the same bank in one cycle.
    if (rd_accept) begin
      if (rd_wrap) begin
        rd_ptr_d               = '0;
        rd_bank_d              = (rd_bank_q == LAST_BANK) ? '0 : rd_bank_q + BANK_ONE;
        bank_full_d[rd_bank_q] = 1'b0;
      end else begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end

    case ({wr_wrap, rd_wrap})
      2'b10:   full_banks_d = full_banks_q + CNT_ONE;
      2'b01:   full_banks_d = full_banks_q - CNT_ONE;
      default: full_banks_d = full_banks_q;
    endcase

    wr_ovf_d     = wr_req & ~wr_accept;
    rd_udf_d     = rd_req & ~rd_accept;
    data_valid_d = rd_accept;
  end

  // Controller state registers.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_busy_q    <= 1'b0;
      rd_busy_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      wr_bank_q    <= '0;
      rd_bank_q    <= '0;
      bank_full_q  <= '0;
      full_banks_q <= '0;
      wr_ovf_q     <= 1'b0;
      rd_udf_q     <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      wr_busy_q    <= wr_busy_d;
      rd_busy_q    <= rd_busy_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      bank_full_q  <= bank_full_d;
      full_banks_q <= full_banks_d;
      wr_ovf_q     <= wr_ovf_d;
      rd_udf_q     <= rd_udf_d;
      data_valid_q <= data_valid_d;
    end
  end

  multibank_buff_ctrl_bank_ram #(
    .WIDTH (WIDTH),
    .WORDS (WORDS),
    .AW    (AW)
  ) u_bank_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_accept),
    .waddr (wr_addr),
    .wdata (data_in),
    .re    (rd_accept),
    .raddr (rd_addr),
    .rdata (data_out)
  );

  assign data_valid = data_valid_q;
  assign full_banks = full_banks_q;
  assign wr_busy    = wr_busy_q;
  assign rd_busy    = rd_busy_q;
  assign wr_ovf     = wr_ovf_q;
  assign rd_udf     = rd_udf_q;

endmodule : multibank_buff_ctrl

// File: tb/tb_multibank_buff_ctrl.sv
// Bench for multibank_buff_ctrl: two instances (2 and 3 banks, 4 words each) share the
// stimulus; each is compared every cycle against a word-count/FIFO reference model.
module tb_multibank_buff_ctrl;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int HIST  = 1024;

  logic             clk;
  logic             rst;
  logic             wt;
  logic             rt;
  logic [WIDTH-1:0] din;

  logic [WIDTH-1:0] do0, do1;
  logic             dv0, dv1;
  logic [1:0]       fb0;
  logic [2:0]       fb1;
  logic             wbz0, wbz1, rbz0, rbz1;
  logic             ovf0, ovf1, udf0, udf1;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: words accepted so far, busy states, expected outputs.
  int               nbank     [2] = '{2, 3};
  int               w_tot     [2];
  int               r_tot     [2];
  bit               wb_m      [2];
  bit               rb_m      [2];
  int               exp_valid [2];
  int               exp_dout  [2];
  int               exp_full  [2];
  int               exp_ovf   [2];
  int               exp_udf   [2];
  logic [WIDTH-1:0] hist      [2][HIST];

  multibank_buff_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NBANK(2)) u_dut2 (
    .clk        (clk),
    .rst        (rst),
    .wr_toggle  (wt),
    .rd_toggle  (rt),
    .data_in    (din),
    .data_out   (do0),
    .data_valid (dv0),
    .full_banks (fb0),
    .wr_busy    (wbz0),
    .rd_busy    (rbz0),
    .wr_ovf     (ovf0),
    .rd_udf     (udf0)
  );

  multibank_buff_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NBANK(3)) u_dut3 (
    .clk        (clk),
    .rst        (rst),
    .wr_toggle  (wt),
    .rd_toggle  (rt),
    .data_in    (din),
    .data_out   (do1),
    .data_valid (dv1),
    .full_banks (fb1),
    .wr_busy    (wbz1),
    .rd_busy    (rbz1),
    .wr_ovf     (ovf1),
    .rd_udf     (udf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d t=%0t: got %0d expected %0d", tag, d, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      w_tot[d] = 0;  r_tot[d] = 0;
      wb_m[d] = 1'b0; rb_m[d] = 1'b0;
      exp_valid[d] = 0; exp_dout[d] = 0; exp_full[d] = 0;
      exp_ovf[d] = 0;   exp_udf[d] = 0;
    end
  endtask

  // One clock edge of behaviour: banks are consecutive DEPTH-word slices of the
  // written stream; full banks are those completely written but not completely read.
  task automatic model_step(input int d);
    int fb;
    bit wreq, rreq, wacc, racc;
    fb   = w_tot[d] / DEPTH - r_tot[d] / DEPTH;
    wreq = wb_m[d] | wt;
    rreq = rb_m[d] | rt;
    wacc = wreq && (fb < nbank[d]);
    racc = rreq && (fb >= 1);
    exp_ovf[d]   = int'(wreq && !wacc);
    exp_udf[d]   = int'(rreq && !racc);
    exp_valid[d] = int'(racc);
    if (racc) begin
      exp_dout[d] = int'(hist[d][r_tot[d] % HIST]);
      r_tot[d]++;
    end
    if (wacc) begin
      hist[d][w_tot[d] % HIST] = din;
      w_tot[d]++;
    end
    wb_m[d] = wb_m[d] ^ wt;
    rb_m[d] = rb_m[d] ^ rt;
    exp_full[d] = w_tot[d] / DEPTH - r_tot[d] / DEPTH;
  endtask

  task automatic compare_all();
    check("data_valid", 0, 32'(dv0),  32'(exp_valid[0]));
    check("data_out",   0, 32'(do0),  32'(exp_dout[0]));
    check("full_banks", 0, 32'(fb0),  32'(exp_full[0]));
    check("wr_busy",    0, 32'(wbz0), 32'(wb_m[0]));
    check("rd_busy",    0, 32'(rbz0), 32'(rb_m[0]));
    check("wr_ovf",     0, 32'(ovf0), 32'(exp_ovf[0]));
    check("rd_udf",     0, 32'(udf0), 32'(exp_udf[0]));
    check("data_valid", 1, 32'(dv1),  32'(exp_valid[1]));
    check("data_out",   1, 32'(do1),  32'(exp_dout[1]));
    check("full_banks", 1, 32'(fb1),  32'(exp_full[1]));
    check("wr_busy",    1, 32'(wbz1), 32'(wb_m[1]));
    check("rd_busy",    1, 32'(rbz1), 32'(rb_m[1]));
    check("wr_ovf",     1, 32'(ovf1), 32'(exp_ovf[1]));
    check("rd_udf",     1, 32'(udf1), 32'(exp_udf[1]));
  endtask

  // Apply current inputs for one edge, then compare just after it.
  task automatic cycle();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Assert reset between edges and check outputs before any clock edge arrives.
  task automatic async_reset();
    wt = 1'b0; rt = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wt = 1'b0; rt = 1'b0; din = '0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Async reset between edges.
    async_reset();

    // Fill both banks of the 2-bank buffer, then overflow on words 9 and 10 (stop pulse).
    wt = 1'b1; din = 16'd1; cycle(); wt = 1'b0;
    for (int i = 2; i <= 9; i++) begin din = WIDTH'(i); cycle(); end
    wt = 1'b1; din = 16'd10; cycle(); wt = 1'b0;

    // Drain with the reader held active, running into underflow once empty.
    rt = 1'b1; din = 16'd0; cycle(); rt = 1'b0;
    repeat (10) cycle();
    rt = 1'b1; cycle(); rt = 1'b0;

    // Read toggles with nothing full: underflow on every request, data_out held.
    async_reset();
    rt = 1'b1; repeat (4) cycle(); rt = 1'b0;
    cycle();

    // Concurrent read of bank 0 while bank 1 is written.
    async_reset();
    wt = 1'b1; din = 16'd1; cycle(); wt = 1'b0;
    din = 16'd2; cycle();
    din = 16'd3; cycle();
    wt = 1'b1; din = 16'd4; cycle(); wt = 1'b0;
    wt = 1'b1; rt = 1'b1; din = 16'd5; cycle(); wt = 1'b0; rt = 1'b0;
    din = 16'd6; cycle();
    din = 16'd7; cycle();
    wt = 1'b1; din = 16'd8; cycle(); wt = 1'b0;
    repeat (6) cycle();
    rt = 1'b1; cycle(); rt = 1'b0;

    // Reset in the middle of a write burst, then restart from scratch.
    wt = 1'b1; din = 16'd100; cycle(); wt = 1'b0;
    din = 16'd101; cycle();
    async_reset();
    wt = 1'b1; din = 16'd200; cycle(); wt = 1'b0;
    din = 16'd201; cycle();
    din = 16'd202; cycle();
    wt = 1'b1; din = 16'd203; cycle(); wt = 1'b0;
    rt = 1'b1; cycle(); rt = 1'b0;
    repeat (4) cycle();
    rt = 1'b1; cycle(); rt = 1'b0;

    // Fill every bank, free one, refill so the write bank wraps to 0, then drain.
    async_reset();
    wt = 1'b1; din = 16'h300; cycle(); wt = 1'b0;
    for (int i = 1; i < 12; i++) begin din = WIDTH'(16'h300 + i); cycle(); end
    wt = 1'b1; din = 16'h30c; cycle(); wt = 1'b0;
    rt = 1'b1; din = 16'h0; cycle(); rt = 1'b0;
    repeat (2) cycle();
    rt = 1'b1; cycle(); rt = 1'b0;
    wt = 1'b1; din = 16'h400; cycle(); wt = 1'b0;
    for (int i = 1; i < 3; i++) begin din = WIDTH'(16'h400 + i); cycle(); end
    wt = 1'b1; din = 16'h403; cycle(); wt = 1'b0;
    rt = 1'b1; cycle(); rt = 1'b0;
    repeat (16) cycle();
    rt = 1'b1; cycle(); rt = 1'b0;

    // Random toggling with random data.
    async_reset();
    for (int n = 0; n < 400; n++) begin
      wt  = ($urandom_range(0, 7) == 0);
      rt  = ($urandom_range(0, 7) == 0);
      din = WIDTH'($urandom);
      cycle();
    end
    wt = 1'b0; rt = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_multibank_buff_ctrl
